instruction_fetch: RTL
======================

Name: instruction_fetch

Overview:
Fetch stage upstream of decode and immediate generation in the RV32I core. Owns the PC and issues word reads to a synchronous instruction memory with 1-cycle read latency. Buffers returned instructions with their PC in a small FIFO and presents them to decode over a valid/ready handshake. Accepts redirects (branch/jump targets) that squash all queued and in-flight fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
DEPTH, 2, FIFO entries (power of two, >=2)

Ports:
CLK  in  1  clock, rising edge
RESET_N  in  1  asynchronous active-low reset
IMEM_REQ  out  1  read request this cycle
IMEM_ADDR  out  32  byte address of request, bits[1:0]=00
IMEM_RDATA  in  32  read data, valid the cycle after IMEM_REQ
INST_VALID  out  1  FIFO head holds a valid instruction
INST_READY  in  1  decode accepts head this cycle
INST  out  32  head instruction word
INST_PC  out  32  PC of head instruction
REDIRECT_VALID  in  1  redirect fetch this cycle
REDIRECT_PC  in  32  new fetch target; bits[1:0] ignored (forced 00)

Behaviour:
- Reset (async assert, sync release): PC=RESET_PC, FIFO empty, in-flight flag=0. Outputs: IMEM_REQ=0, IMEM_ADDR=RESET_PC, INST_VALID=0, INST=0, INST_PC=0. A response arriving after reset is dropped.
- State: pc[31:0], inflight (1 bit, request issued last cycle and not squashed), FIFO storage {inst,pc} x DEPTH, rd/wr pointers, count (0..DEPTH).
- pop = INST_VALID & INST_READY; INST_VALID = (count!=0) & ~REDIRECT_VALID.
- Issue rule: IMEM_REQ = ~REDIRECT_VALID & (count + inflight - pop < DEPTH). IMEM_ADDR = pc. On issue: pc <= pc+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0), inflight <= 1; else inflight <= 0.
- Response: if inflight, IMEM_RDATA with its PC (registered issue address) is pushed at end of that cycle. Credit rule guarantees no push into a full FIFO; a push into full is an assertion failure.
- Simultaneous push and pop: count unchanged; with count==1 both apply (head replaced by new entry next cycle).
- No bypass: issue in cycle t -> push end of t+1 -> INST_VALID at t+2 (2-cycle fetch latency). Steady state with INST_READY=1: one instruction per cycle.
- Backpressure: INST_READY=0 holds INST/INST_PC stable while INST_VALID=1; issuing stops once count+inflight reaches DEPTH.
- Redirect (REDIRECT_VALID=1 in cycle t), priority over everything: FIFO flushed (count<=0), no pop, no push of the response in cycle t, pc <= {REDIRECT_PC[31:2],2'b00}, inflight <= 0, IMEM_REQ=0 in t. Response in t+1 belonging to pre-redirect request is not pushed (inflight already 0). First target fetch issued t+1, INST_VALID at t+3 with INST_PC = target.
- Back-to-back redirects: last one wins; each cycle restarts the sequence.
- Reset mid-operation: immediate return to reset state regardless of FIFO/inflight contents.
- Memory responses are never accepted without a prior IMEM_REQ; IMEM_RDATA ignored when inflight=0.

Test Plan:
- Reset release, RESET_PC=32'h100, INST_READY=1, mem[i]=i -> IMEM_ADDR 100,104,108… one per cycle; INST_VALID first high 2 cycles after first IMEM_REQ with INST_PC=100, then 104,108 every cycle.
- Backpressure: stream, drop INST_READY for 5 cycles at head PC=108 -> INST/INST_PC held at 108, IMEM_REQ stops after FIFO+inflight=2, no lost/duplicated PC when READY returns (10C follows 108).
- Redirect with in-flight fetch: REDIRECT_VALID with REDIRECT_PC=32'h200 while FIFO holds 2 entries and a request is in flight -> INST_VALID=0 that cycle, stale data never presented, next INST_PC=200 appears 3 cycles after redirect, then 204.
- Misaligned redirect REDIRECT_PC=32'h203 -> IMEM_ADDR=200.
- PC wrap: RESET_PC=32'hFFFF_FFF8 -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000, presented in order.
- Reset asserted mid-stream with FIFO full and inflight=1 -> INST_VALID/IMEM_REQ drop immediately; after release fetch restarts at RESET_PC, old response never appears.

Source files
------------

// File: rtl/instruction_fetch.sv
// RV32I fetch stage: owns the PC, issues word reads to a 1-cycle-latency
// instruction memory and queues {inst, pc} pairs for decode.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        CLK,
    input  logic        RESET_N,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic [31:0] IMEM_RDATA,
    output logic        INST_VALID,
    input  logic        INST_READY,
    output logic [31:0] INST,
    output logic [31:0] INST_PC,
    input  logic        REDIRECT_VALID,
    input  logic [31:0] REDIRECT_PC
);

    localparam int              PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CW    = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]   FULL  = CW'(DEPTH);
    localparam logic [CW:0]     LIMIT = (CW + 1)'(DEPTH);

    logic [31:0]   r_pc;
    logic [31:0]   r_req_pc;
    logic          r_inflight;
    logic [31:0]   r_inst_mem [DEPTH];
    logic [31:0]   r_pc_mem   [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic          w_pop;
    logic          w_push;
    logic          w_issue;
    logic [CW:0]   w_credit;
    logic [31:0]   w_redirect_pc;

    assign INST_VALID    = (r_count != '0) & ~REDIRECT_VALID;
    assign w_pop         = INST_VALID & INST_READY;
    // A redirect squashes the response of last cycle's request.
    assign w_push        = r_inflight & ~REDIRECT_VALID;
    // Slots already spoken for: queued entries plus the response on its way,
    // less the entry leaving this cycle.
    assign w_credit      = {1'b0, r_count} + (CW + 1)'(r_inflight) - (CW + 1)'(w_pop);
    assign w_issue       = RESET_N & ~REDIRECT_VALID & (w_credit < LIMIT);
    assign w_redirect_pc = REDIRECT_PC & ~32'h3;

    assign IMEM_REQ  = w_issue;
    assign IMEM_ADDR = r_pc;
    assign INST      = r_inst_mem[r_rd_ptr];
    assign INST_PC   = r_pc_mem[r_rd_ptr];

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_pc       <= RESET_PC;
            r_req_pc   <= RESET_PC;
            r_inflight <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else if (REDIRECT_VALID) begin
            r_pc       <= w_redirect_pc;
            r_inflight <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_pc     <= r_pc + 32'd4;
                r_req_pc <= r_pc;
            end
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: the entry storage is reset so INST/INST_PC read zero out of reset;
    // deeper queues that do not need that would drop the reset branch here.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_inst_mem[i] <= '0;
                r_pc_mem[i]   <= '0;
            end
        end else if (w_push) begin
            r_inst_mem[r_wr_ptr] <= IMEM_RDATA;
            r_pc_mem[r_wr_ptr]   <= r_req_pc;
        end
    end

    a_no_overflow: assert property (@(posedge CLK) disable iff (!RESET_N)
        !(w_push && (r_count == FULL)));

endmodule
